// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite constants and the write-address entry record.
package axi4_lite_pkg;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;
  localparam logic [1:0] RESP_OKAY        = 2'b00;
  localparam logic [1:0] RESP_SLVERR      = 2'b10;

  localparam int AXI_ADDR_W = 32;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [2:0]            prot;
    logic                  err;
  } aw_entry_t;

endpackage

// File: rtl/axi4_skid_fifo2.sv
// Generic 2-entry FIFO: one cycle from push to out_vld, head read straight from storage.
// in_rdy is a flop loaded with (count_next < 2), so a full FIFO drained by one pop reopens an edge later.
module axi4_skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_take,
  output logic [1:0]   count
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push;
  logic         pop;
  logic [1:0]   count_next;

  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_take;
  assign out_vld = (count != EMPTY);
  assign out_dat = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case (count)
      EMPTY:   if (push) count_next = ONE;
      ONE:     if (push && !pop) count_next = FULL;
               else if (pop && !push) count_next = EMPTY;
      FULL:    if (pop) count_next = ONE;
      default: count_next = EMPTY;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      count  <= EMPTY;
      in_rdy <= 1'b0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      count  <= count_next;
      in_rdy <= (count_next != FULL);
      if (push) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

endmodule

// File: rtl/axi4_slave_write_address_channel.sv
// AXI4-Lite subordinate write-address channel: AW handshake into a 2-deep FIFO, head offered downstream
// one cycle after acceptance; AWREADY is registered, bad addresses are flagged and still queued in order.
module axi4_slave_write_address_channel
  import axi4_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(32'h0000_1000)
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [2:0]            AWPROT,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  output logic [ADDR_WIDTH-1:0] aw_addr_o,
  output logic [2:0]            aw_prot_o,
  output logic                  aw_err_o,
  output logic                  aw_valid_o,
  input  logic                  aw_take_i,
  output logic [1:0]            aw_count_o,
  output logic                  aw_IDLE
);

  localparam int ENTRY_W = ADDR_WIDTH + 4;

  logic               aw_err;
  logic [ENTRY_W-1:0] wr_dat;
  logic [ENTRY_W-1:0] rd_dat;
  logic [1:0]         count;

  // Misaligned or beyond the register window; the downstream stage answers these with SLVERR.
  assign aw_err = (AWADDR[1:0] != 2'b00) || (AWADDR >= ADDR_LIMIT);
  assign wr_dat = {AWADDR, AWPROT, aw_err};

  axi4_skid_fifo2 #(
    .W(ENTRY_W)
  ) u_fifo (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .in_vld   (AWVALID),
    .in_rdy   (AWREADY),
    .in_dat   (wr_dat),
    .out_vld  (aw_valid_o),
    .out_dat  (rd_dat),
    .out_take (aw_take_i),
    .count    (count)
  );

  assign {aw_addr_o, aw_prot_o, aw_err_o} = rd_dat;
  assign aw_count_o = count;
  assign aw_IDLE    = (count == 2'd0) && !(AWVALID && AWREADY);

endmodule

// File: tb/tb_axi4_slave_write_address_channel.sv
// Bench for the AXI4-Lite write-address channel: reference queue model plus vector table and directed sequences.
module tb_axi4_slave_write_address_channel;
  import axi4_lite_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] AWADDR = '0;
  logic [2:0]  AWPROT = AXI_PROT_DEFAULT;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] aw_addr_o;
  logic [2:0]  aw_prot_o;
  logic        aw_err_o;
  logic        aw_valid_o;
  logic        aw_take_i = 1'b0;
  logic [1:0]  aw_count_o;
  logic        aw_IDLE;

  axi4_slave_write_address_channel dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .AWADDR     (AWADDR),
    .AWPROT     (AWPROT),
    .AWVALID    (AWVALID),
    .AWREADY    (AWREADY),
    .aw_addr_o  (aw_addr_o),
    .aw_prot_o  (aw_prot_o),
    .aw_err_o   (aw_err_o),
    .aw_valid_o (aw_valid_o),
    .aw_take_i  (aw_take_i),
    .aw_count_o (aw_count_o),
    .aw_IDLE    (aw_IDLE)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
  endfunction

  // Reference model: expected entries queued on each modelled push, retired on each modelled pop.
  aw_entry_t sb_q[$];
  logic      m_rdy = 1'b0;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sb_q.delete();
      m_rdy = 1'b0;
    end else begin
      automatic bit push = AWVALID && m_rdy;
      automatic bit pop  = aw_take_i && (sb_q.size() > 0);
      if (pop) void'(sb_q.pop_front());
      if (push) sb_q.push_back('{addr: AWADDR, prot: AWPROT, err: model_err(AWADDR)});
      m_rdy = (sb_q.size() < 2);
    end
  end

  always @(negedge ACLK) begin
    if (chk_en) begin
      check("sb_awready", 32'(AWREADY), 32'(m_rdy));
      check("sb_count", 32'(aw_count_o), 32'(sb_q.size()));
      check("sb_valid", 32'(aw_valid_o), 32'(sb_q.size() > 0));
      check("sb_idle", 32'(aw_IDLE), 32'((sb_q.size() == 0) && !(AWVALID && m_rdy)));
      if (sb_q.size() > 0) begin
        check("sb_head_addr", aw_addr_o, sb_q[0].addr);
        check("sb_head_prot", 32'(aw_prot_o), 32'(sb_q[0].prot));
        check("sb_head_err", 32'(aw_err_o), 32'(sb_q[0].err));
      end
    end
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push_one(input logic [31:0] a);
    AWADDR  = a;
    AWPROT  = AXI_PROT_DEFAULT;
    AWVALID = 1'b1;
    step();
    AWVALID = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  prot;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{addr: 32'h0000_0013, prot: 3'b010, exp_err: 1'b1};
    vecs[1] = '{addr: 32'h0000_1000, prot: 3'b000, exp_err: 1'b1};
    vecs[2] = '{addr: 32'h0000_0FFC, prot: 3'b001, exp_err: 1'b0};
    vecs[3] = '{addr: 32'h0000_0000, prot: 3'b111, exp_err: 1'b0};
    vecs[4] = '{addr: 32'hFFFF_FFFC, prot: 3'b100, exp_err: 1'b1};
    vecs[5] = '{addr: 32'h0000_0FFE, prot: 3'b011, exp_err: 1'b1};

    // Reset state and release
    #1;
    check("rst_awready", 32'(AWREADY), 32'd0);
    check("rst_valid", 32'(aw_valid_o), 32'd0);
    check("rst_count", 32'(aw_count_o), 32'd0);
    check("rst_err", 32'(aw_err_o), 32'd0);
    check("rst_addr", aw_addr_o, 32'd0);
    check("rst_prot", 32'(aw_prot_o), 32'd0);
    check("rst_idle", 32'(aw_IDLE), 32'd1);
    step();
    step();
    ARESETN = 1'b1;
    chk_en  = 1'b1;
    check("rel_awready_before_edge", 32'(AWREADY), 32'd0);
    step();
    check("rel_awready_first_edge", 32'(AWREADY), 32'd1);
    check("rel_idle", 32'(aw_IDLE), 32'd1);

    // Single write
    push_one(32'h0000_0010);
    check("single_valid", 32'(aw_valid_o), 32'd1);
    check("single_addr", aw_addr_o, 32'h10);
    check("single_err", 32'(aw_err_o), 32'd0);
    check("single_count", 32'(aw_count_o), 32'd1);
    aw_take_i = 1'b1;
    step();
    aw_take_i = 1'b0;
    check("single_drain_count", 32'(aw_count_o), 32'd0);
    check("single_drain_idle", 32'(aw_IDLE), 32'd1);

    // Fill to full, hold a third address, one pop reopens AWREADY an edge later
    push_one(32'h4);
    push_one(32'h8);
    check("full_count", 32'(aw_count_o), 32'd2);
    check("full_awready", 32'(AWREADY), 32'd0);
    AWADDR  = 32'hC;
    AWVALID = 1'b1;
    step();
    check("full_hold_count", 32'(aw_count_o), 32'd2);
    check("full_hold_head", aw_addr_o, 32'h4);
    aw_take_i = 1'b1;
    step();
    aw_take_i = 1'b0;
    check("full_pop_count", 32'(aw_count_o), 32'd1);
    check("full_pop_awready", 32'(AWREADY), 32'd1);
    check("full_pop_head", aw_addr_o, 32'h8);
    step();
    AWVALID = 1'b0;
    check("full_c_accepted", 32'(aw_count_o), 32'd2);
    aw_take_i = 1'b1;
    step();
    check("order_second_c", aw_addr_o, 32'hC);
    step();
    aw_take_i = 1'b0;
    check("order_drained", 32'(aw_count_o), 32'd0);

    // Simultaneous push and pop while holding one entry
    push_one(32'h20);
    AWADDR    = 32'h24;
    AWVALID   = 1'b1;
    aw_take_i = 1'b1;
    step();
    AWVALID = 1'b0;
    check("sim_count", 32'(aw_count_o), 32'd1);
    check("sim_valid", 32'(aw_valid_o), 32'd1);
    check("sim_head", aw_addr_o, 32'h24);
    step();
    aw_take_i = 1'b0;

    // Error-flag vector table
    for (int i = 0; i < 6; i++) begin
      AWADDR  = vecs[i].addr;
      AWPROT  = vecs[i].prot;
      AWVALID = 1'b1;
      step();
      AWVALID = 1'b0;
      check($sformatf("vec%0d_err", i), 32'(aw_err_o), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_addr", i), aw_addr_o, vecs[i].addr);
      check($sformatf("vec%0d_prot", i), 32'(aw_prot_o), 32'(vecs[i].prot));
      aw_take_i = 1'b1;
      step();
      aw_take_i = 1'b0;
    end

    // Asynchronous reset while full
    push_one(32'h30);
    push_one(32'h34);
    check("prereset_count", 32'(aw_count_o), 32'd2);
    #3;
    ARESETN = 1'b0;
    #1;
    check("midrst_valid", 32'(aw_valid_o), 32'd0);
    check("midrst_count", 32'(aw_count_o), 32'd0);
    check("midrst_awready", 32'(AWREADY), 32'd0);
    step();
    ARESETN = 1'b1;
    AWADDR  = 32'h40;
    AWVALID = 1'b1;
    step();
    check("postrst_no_push", 32'(aw_valid_o), 32'd0);
    step();
    AWVALID = 1'b0;
    check("postrst_count", 32'(aw_count_o), 32'd1);
    check("postrst_head", aw_addr_o, 32'h40);
    aw_take_i = 1'b1;
    step();
    aw_take_i = 1'b0;
    check("postrst_drained", 32'(aw_count_o), 32'd0);
    step();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
